// File: rtl/xc_aes_pkg.sv
// Shared AES constants for the XCrypto lightweight AES path: reduction polynomial,
// MixColumns coefficient sets, mixer FSM encodings and a small GF(2^8) multiply helper.
package xc_aes_pkg;

  typedef logic [3:0][7:0] xc_aes_col_t;

  localparam logic [7:0] XC_AES_RPOLY = 8'h1B;

  // Index 0 multiplies a_k, index 1 multiplies a_{k+1}, and so on.
  localparam xc_aes_col_t XC_AES_FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
  localparam xc_aes_col_t XC_AES_INV_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  function automatic logic [7:0] xc_aes_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? XC_AES_RPOLY : 8'h00);
  endfunction

  // Every coefficient in use fits in four bits, so a four-step xtime chain suffices.
  function automatic logic [7:0] xc_aes_gmul(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = x;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xc_aes_xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/xc_aesmix_if.sv
// Execute-stage handshake bundle for xc_aesmix: operands, flush, and the
// single-cycle ready/result response.
interface xc_aesmix_if;
  logic        flush;
  logic [31:0] flush_data;
  logic        valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        enc;
  logic        ready;
  logic [31:0] result;

  modport master (
    output flush, flush_data, valid, rs1, rs2, enc,
    input  ready, result
  );

  modport slave (
    input  flush, flush_data, valid, rs1, rs2, enc,
    output ready, result
  );
endinterface

// File: rtl/xc_aesmix_gf.sv
// One MixColumns output byte: GF(2^8) dot product of a pre-rotated column with the
// forward coefficients, or the inverse set when XC_AESMIX_INV_EN is defined.
module xc_aesmix_gf
  import xc_aes_pkg::*;
(
  input  xc_aes_col_t x_i,
  input  logic        inv_i,
  output logic [7:0]  y_o
);

  xc_aes_col_t fwd_term;
  logic [7:0]  y_fwd;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
    assign fwd_term[gi] = xc_aes_gmul(x_i[gi], XC_AES_FWD_COEF[gi][3:0]);
  end

  always_comb begin
    y_fwd = 8'h00;
    for (int i = 0; i < 4; i++) y_fwd = y_fwd ^ fwd_term[i];
  end

`ifdef XC_AESMIX_INV_EN
  xc_aes_col_t inv_term;
  logic [7:0]  y_inv;

  for (genvar gi = 0; gi < 4; gi++) begin : g_inv
    assign inv_term[gi] = xc_aes_gmul(x_i[gi], XC_AES_INV_COEF[gi][3:0]);
  end

  always_comb begin
    y_inv = 8'h00;
    for (int i = 0; i < 4; i++) y_inv = y_inv ^ inv_term[i];
  end

  assign y_o = inv_i ? y_inv : y_fwd;
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign y_o        = y_fwd;
`endif

endmodule

// File: rtl/xc_aesmix.sv
// Multi-cycle AES (Inv)MixColumns unit: one output byte per cycle over four cycles.
// Define XC_AESMIX_INV_EN to compile in InvMixColumns (selected by enc = 0).
module xc_aesmix
  import xc_aes_pkg::*;
#(
  parameter bit XC_AESMIX_ZERO_RESULT = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  xc_aesmix_if.slave bus
);

  logic [1:0]      fsm_q, fsm_d;
  logic [2:0][7:0] b_q, b_d;
  xc_aes_col_t     col_a;
  xc_aes_col_t     col_rot;
  logic            inv;
  logic [7:0]      b_comb;
  logic            ready;
  logic [31:0]     full_result;

  assign col_a = {bus.rs2[31:24], bus.rs2[23:16], bus.rs1[15:8], bus.rs1[7:0]};

  // State Sk feeds a_k, a_{k+1}, a_{k+2}, a_{k+3}; the 2-bit add wraps mod 4.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign col_rot[gi] = col_a[fsm_q + 2'(gi)];
  end

`ifdef XC_AESMIX_INV_EN
  assign inv = ~bus.enc;
`else
  logic unused_enc;
  assign unused_enc = bus.enc;
  assign inv        = 1'b0;
`endif

  xc_aesmix_gf u_gf (
    .x_i   (col_rot),
    .inv_i (inv),
    .y_o   (b_comb)
  );

  assign ready = bus.valid & (fsm_q == S3) & ~bus.flush & ~reset;

  always_comb begin
    fsm_d = fsm_q;
    b_d   = b_q;
    if (bus.flush) begin
      fsm_d = S0;
      b_d   = bus.flush_data[23:0];
    end else if (bus.valid) begin
      fsm_d = fsm_q + 2'd1;
      case (fsm_q)
        S0:      b_d[0] = b_comb;
        S1:      b_d[1] = b_comb;
        S2:      b_d[2] = b_comb;
        default: b_d    = b_q;
      endcase
    end else begin
      // Dropping valid mid-column abandons it; partial bytes are kept as-is.
      fsm_d = S0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q <= S0;
      b_q   <= '0;
    end else begin
      fsm_q <= fsm_d;
      b_q   <= b_d;
    end
  end

  assign full_result = {b_comb, b_q};
  assign bus.ready   = ready;
  assign bus.result  = (ready || !XC_AESMIX_ZERO_RESULT) ? full_result : 32'h0;

  logic unused_bits;
  assign unused_bits = ^{bus.rs1[31:16], bus.rs2[15:0], bus.flush_data[31:24]};

endmodule

// File: tb/tb_xc_aesmix.sv
// Scoreboard bench for xc_aesmix: directed FIPS-197 vectors, abort/flush/reset cases
// and randomized columns against a shift-and-reduce GF(2^8) reference model.
module tb_xc_aesmix;

`ifdef XC_AESMIX_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sbq[$];
  exp_t nzq[$];
  logic [23:0] exp_b;

  xc_aesmix_if bus ();
  xc_aesmix_if bus_nz ();

  assign bus_nz.flush      = bus.flush;
  assign bus_nz.flush_data = bus.flush_data;
  assign bus_nz.valid      = bus.valid;
  assign bus_nz.rs1        = bus.rs1;
  assign bus_nz.rs2        = bus.rs2;
  assign bus_nz.enc        = bus.enc;

  xc_aesmix dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Second instance with the zero-gating off exposes b0..b2 while ready is low.
  xc_aesmix #(.XC_AESMIX_ZERO_RESULT(1'b0)) dut_nz (
    .clock (clk),
    .reset (rst),
    .bus   (bus_nz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] mix_ref(input logic [31:0] r1, input logic [31:0] r2, input bit e);
    logic [7:0]  a[4];
    logic [7:0]  c[4];
    logic [7:0]  s;
    logic [31:0] r;
    a[0] = r1[7:0];
    a[1] = r1[15:8];
    a[2] = r2[23:16];
    a[3] = r2[31:24];
    if (INV_EN && !e) c = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else              c = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      s = 8'h00;
      for (int j = 0; j < 4; j++) s = s ^ gmul_ref(c[j], a[(i + j) % 4]);
      r[8*i +: 8] = s;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] r1, input logic [31:0] r2, input bit e);
    bus.valid = 1'b1;
    bus.rs1   = r1;
    bus.rs2   = r2;
    bus.enc   = e;
  endtask

  task automatic op(input logic [31:0] r1, input logic [31:0] r2, input bit e, input logic [31:0] exp_val);
    drive_op(r1, r2, e);
    sbq.push_back('{cyc + 3, exp_val});
    exp_b = exp_val[23:0];
    repeat (4) tick();
  endtask

  task automatic idle(input int n);
    bus.valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.rs1 = $urandom;
      bus.rs2 = $urandom;
      bus.enc = 1'($urandom_range(0, 1));
      nzq.push_back('{cyc, {8'h00, exp_b}});
      tick();
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents (or should present) output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        checks++;
        if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
          errors++;
          $display("FAIL ready_timing cyc=%0d: got ready=1 result=%h, required no ready (next expected cyc %0d)",
                   cyc, bus.result, (sbq.size() != 0) ? sbq[0].cyc : -1);
        end else begin
          e = sbq.pop_front();
          checks++;
          if (bus.result !== e.val) begin
            errors++;
            $display("FAIL result cyc=%0d: got %h, required %h", cyc, bus.result, e.val);
          end
          checks++;
          if (bus_nz.result !== e.val) begin
            errors++;
            $display("FAIL result_nz cyc=%0d: got %h, required %h", cyc, bus_nz.result, e.val);
          end
          $display("cyc=%0d ready result=%h expected=%h", cyc, bus.result, e.val);
        end
      end else begin
        checks++;
        if (bus.result !== 32'h0) begin
          errors++;
          $display("FAIL zero_result cyc=%0d: got %h with ready=%b, required 00000000", cyc, bus.result, bus.ready);
        end
        if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
          e = sbq.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_ready cyc=%0d: got ready=%b, required ready with result %h at cyc %0d",
                   cyc, bus.ready, e.val, e.cyc);
        end
      end
      checks++;
      if (bus_nz.ready !== bus.ready) begin
        errors++;
        $display("FAIL ready_nz cyc=%0d: got %b, required %b", cyc, bus_nz.ready, bus.ready);
      end
      if (nzq.size() != 0 && nzq[0].cyc <= cyc) begin
        e = nzq.pop_front();
        checks++;
        if (e.cyc != cyc || bus_nz.result[23:0] !== e.val[23:0]) begin
          errors++;
          $display("FAIL byte_regs cyc=%0d: got %h, required %h (for cyc %0d)",
                   cyc, bus_nz.result[23:0], e.val[23:0], e.cyc);
        end else begin
          $display("cyc=%0d byte_regs=%h", cyc, bus_nz.result[23:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r1, r2, fd;
    bit          e;
    checks = 0;
    errors = 0;
    exp_b  = 24'h0;
    rst            = 1'b1;
    bus.valid      = 1'b0;
    bus.flush      = 1'b0;
    bus.flush_data = 32'h0;
    bus.rs1        = 32'h0;
    bus.rs2        = 32'h0;
    bus.enc        = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    idle(2);

    op(32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e);
    idle(2);
`ifdef XC_AESMIX_INV_EN
    op(32'h00004d8e, 32'hbca10000, 1'b0, 32'h455313db);
`else
    op(32'h000013db, 32'h45530000, 1'b0, 32'hbca14d8e);
`endif
    idle(1);

    op(32'h00000af2, 32'h5c220000, 1'b1, 32'h9d58dc9f);
    op(32'h00000101, 32'h01010000, 1'b1, 32'h01010101);
    idle(2);

    // Abort in S2: b0/b1 updated, b2 kept, no ready; retry has full latency.
    drive_op(32'h000013db, 32'h45530000, 1'b1);
    tick();
    tick();
    bus.valid = 1'b0;
    tick();
    exp_b = {exp_b[23:16], 16'h4d8e};
    nzq.push_back('{cyc, {8'h00, exp_b}});
    op(32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e);
    idle(2);

    // Flush in S1 with valid held.
    drive_op(32'h00000af2, 32'h5c220000, 1'b1);
    tick();
    bus.flush      = 1'b1;
    bus.flush_data = 32'h00a5b6c7;
    tick();
    bus.flush = 1'b0;
    nzq.push_back('{cyc, 32'h00a5b6c7});
    op(32'h00000af2, 32'h5c220000, 1'b1, 32'h9d58dc9f);
    idle(2);

    // Flush in S3 with valid high must suppress ready.
    drive_op(32'h000013db, 32'h45530000, 1'b1);
    repeat (3) tick();
    fd             = $urandom;
    bus.flush      = 1'b1;
    bus.flush_data = fd;
    tick();
    bus.flush = 1'b0;
    exp_b     = fd[23:0];
    idle(2);

    // Reset in S2 with valid held: operation discarded, byte registers cleared.
    drive_op(32'h00000af2, 32'h5c220000, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nzq.push_back('{cyc, 32'h0});
    op(32'h00000af2, 32'h5c220000, 1'b1, 32'h9d58dc9f);
    idle(2);

    for (int n = 0; n < 40; n++) begin
      r1 = $urandom;
      r2 = $urandom;
      e  = 1'($urandom_range(0, 1));
      op(r1, r2, e, mix_ref(r1, r2, e));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    idle(4);

    checks++;
    if (sbq.size() != 0 || nzq.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d result and %0d byte expectations pending, required 0",
               sbq.size(), nzq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xc_aesmix.md
# xc_aesmix

Multi-cycle AES MixColumns / InvMixColumns instruction unit for the XCrypto lightweight AES path. It is the round-function counterpart to the SubBytes unit: SubBytes produces substituted bytes, and this block diffuses one 32-bit state column. It computes one output byte per cycle through a single GF(2^8) dot-product datapath. It sits beside the SubBytes unit in the co-processor execute stage and shares its valid/ready/flush contract.

## Interface
- `XC_AESMIX_ZERO_RESULT`, default 1'b1: drive `result` to zero whenever `ready` is low.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: abort the current operation and load `flush_data` into the byte registers.
- `flush_data` in 32: flush value; bits [23:0] go to b0..b2.
- `valid` in 1: operands are valid. Must stay high, with operands stable, until `ready`.
- `rs1` in 32: a0 = rs1[7:0], a1 = rs1[15:8].
- `rs2` in 32: a2 = rs2[23:16], a3 = rs2[31:24].
- `enc` in 1: 1 selects MixColumns, 0 selects InvMixColumns. Sampled every cycle, so it must be held stable.
- `ready` out 1: result valid this cycle. Single-cycle pulse.
- `result` out 32: {b3, b2, b1, b0}.

## Operation
- Column transform, indices mod 4:
  - Forward: b_i = 02·a_i ^ 03·a_{i+1} ^ 01·a_{i+2} ^ 01·a_{i+3}.
  - Inverse coefficients: 0e, 0b, 0d, 09 in the same rotation.
- GF(2^8) arithmetic uses reduction polynomial 0x11B (xtime XOR 0x1B on carry-out). All intermediate values are 8 bits.
- State: `fsm` is a 2-bit counter (S0..S3) plus byte registers b0, b1, b2.
- In state Sk with `valid` high, the datapath computes b_k.
  - S0..S2: the byte is registered into b_k and `fsm` increments.
  - S3: b3 is driven combinationally, `ready` is high, and `fsm` wraps to S0.
- `valid` low in S1..S3 aborts the operation: `fsm` returns to S0 and b0..b2 keep their values. No `ready` is produced.
- Back-to-back operations: if `valid` stays high after `ready`, the next operation starts in S0 on the following cycle with the new operands.
- `flush` (highest priority after `reset`):
  - `fsm` goes to S0.
  - b0 ← flush_data[7:0], b1 ← [15:8], b2 ← [23:16].
  - No `ready` is produced that cycle.
- `reset`: `fsm` goes to S0, b0..b2 go to 0. A reset mid-operation discards the operation.
- `ready` = valid & (fsm == S3). It is never high while `flush` or `reset` is high.
- `result`:
  - When `ready` is high: {b3_comb, b2, b1, b0}.
  - When `ready` is low: zero if `XC_AESMIX_ZERO_RESULT`, otherwise {b3_comb, b2, b1, b0}.

## Timing
- Latency: `valid` rising at cycle 0 gives `ready` at cycle 3, combinational within that cycle (4 cycles total).
- Throughput: one column per 4 cycles.
- Reset values: `ready` = 0, `result` = 0.
- No path runs from `result` to `valid`. The combinational path is: operands/`enc` → GF datapath → `result`.

## Configuration
- `XC_AESMIX_INV_EN` defined:
  - The inverse coefficient set is compiled in.
  - `enc` = 0 performs InvMixColumns.
- `XC_AESMIX_INV_EN` undefined:
  - Only the forward datapath exists and `enc` is ignored; every operation is MixColumns.
  - Latency and handshake are unchanged.

## Structure
- Shared package `xc_aes_pkg`:
  - Reduction constant `XC_AES_RPOLY` = 8'h1B.
  - Forward and inverse coefficient constants.
  - `fsm` state encodings S0..S3.
- Sub-module `xc_aesmix_gf`: combinational. Inputs are four bytes, rotated by the caller, plus `inv`; output is one byte. It contains xtime-chain multiplies by 2/3 (forward) or 9/b/d/e (inverse, behind the macro).
- Top level: FSM, byte registers, operand rotation mux, result assembly.

## Test plan
- FIPS-197 forward vector: enc=1, rs1=0x000013db, rs2=0x45530000, valid held → `ready` at cycle 3 with `result` = 0xbca14d8e. `result` = 0 in cycles 0–2.
- Inverse (macro defined): enc=0, rs1=0x00004d8e, rs2=0xbca10000 → `result` = 0x455313db at cycle 3.
- Second vector, back-to-back: column f2 0a 22 5c (rs1=0x00000af2, rs2=0x5c220000) followed immediately by 01 01 01 01 → 0x9d58dc9f at cycle 3, then 0x01010101 at cycle 7.
- Abort: `valid` drops in S2 → no `ready`. Re-assert with the first vector → `ready` is again exactly 3 cycles later with the correct result.
- Flush mid-operation: flush_data=0x00a5b6c7 in S1 → `fsm` goes to S0, b0..b2 = c7, b6, a5 (visible through `result` with `XC_AESMIX_ZERO_RESULT`=0). The next op has full 4-cycle latency.
- Reset in S2 → `ready`=0 and `result`=0 the next cycle. A subsequent operation is correct.
